// File: rtl/timer_sched_pkg.sv
// rtl/timer_sched_pkg.sv - shared constants, FSM states and helpers for timer_sched
package timer_sched_pkg;

    // Width of remaining-tick and elapsed-tick arithmetic
    localparam int REM_W = 32;

    // Timer register byte offsets
    localparam logic [31:0] TIMER_OFF = 32'h0;
    localparam logic [31:0] CTRL_OFF  = 32'h4;
    localparam logic [31:0] CMP_OFF   = 32'h8;

    // CTRL fields
    localparam logic [31:0] CTRL_EN          = 32'h1;
    localparam int          CTRL_PRESC_SHIFT = 3;

    typedef enum logic [2:0] {
        ST_CFG,
        ST_IDLE,
        ST_WAIT,
        ST_SYNC,
        ST_UPDATE,
        ST_MERGE,
        ST_FIRE,
        ST_PROG
    } state_t;

    // CTRL word that enables the timer with the given prescaler
    function automatic logic [31:0] ctrl_word(input int presc);
        return (32'(presc) << CTRL_PRESC_SHIFT) | CTRL_EN;
    endfunction

endpackage

// File: rtl/timer_sched_apb_master.sv
// rtl/timer_sched_apb_master.sv - single-transfer APB master engine
module timer_sched_apb_master #(
    parameter int ADDR_W = 12
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              start,
    input  logic              write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              done,
    output logic [31:0]       rdata,
    output logic [ADDR_W-1:0] PADDR,
    output logic [31:0]       PWDATA,
    output logic              PWRITE,
    output logic              PSEL,
    output logic              PENABLE,
    input  logic [31:0]       PRDATA,
    input  logic              PREADY
);

    // Idle (PSEL=0) -> SETUP (PSEL=1) -> ACCESS (PENABLE=1) until PREADY; start is ignored while busy
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            PWRITE  <= 1'b0;
            PADDR   <= '0;
            PWDATA  <= '0;
        end else if (!PSEL) begin
            if (start) begin
                PSEL   <= 1'b1;
                PWRITE <= write;
                PADDR  <= addr;
                PWDATA <= wdata;
            end
        end else if (!PENABLE) begin
            PENABLE <= 1'b1;
        end else if (PREADY) begin
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            PWRITE  <= 1'b0;
        end
    end

    assign done  = PSEL & PENABLE & PREADY;
    assign rdata = PRDATA;

endmodule

// File: rtl/timer_sched.sv
// rtl/timer_sched.sv - one-shot alarm scheduler sharing one APB timer; optional TIMER_SCHED_CANCEL_EN
module timer_sched
    import timer_sched_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int APB_ADDR_WIDTH = 12,
    parameter int PRESCALE       = 1
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic [NUM_REQ-1:0]        arm_i,
    input  logic [NUM_REQ-1:0][31:0]  delay_i,
`ifdef TIMER_SCHED_CANCEL_EN
    input  logic [NUM_REQ-1:0]        cancel_i,
`endif
    output logic [NUM_REQ-1:0]        done_o,
    output logic                      busy_o,
    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [31:0]               PWDATA,
    output logic                      PWRITE,
    output logic                      PSEL,
    output logic                      PENABLE,
    input  logic [31:0]               PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR,
    input  logic                      irq_cmp_i
);

    localparam logic [APB_ADDR_WIDTH-1:0] ADDR_TIMER = APB_ADDR_WIDTH'(TIMER_OFF);
    localparam logic [APB_ADDR_WIDTH-1:0] ADDR_CTRL  = APB_ADDR_WIDTH'(CTRL_OFF);
    localparam logic [APB_ADDR_WIDTH-1:0] ADDR_CMP   = APB_ADDR_WIDTH'(CMP_OFF);
    localparam logic [31:0]               CTRL_WORD  = ctrl_word(PRESCALE);

    state_t                          state_q, state_d;
    logic [NUM_REQ-1:0]              pend_q, act_q;
    logic [NUM_REQ-1:0][REM_W-1:0]   dly_q, rem_q;
    logic [REM_W-1:0]                cmp_q, elapsed_q, min_rem;
    logic                            hit_q;
    logic [NUM_REQ-1:0]              expired, cancel_v, arm_v;
    logic                            apb_start, apb_write, apb_done;
    logic [APB_ADDR_WIDTH-1:0]       apb_addr;
    logic [31:0]                     apb_wdata, apb_rdata;
    logic                            unused_pslverr;

    assign unused_pslverr = PSLVERR;

`ifdef TIMER_SCHED_CANCEL_EN
    assign cancel_v = cancel_i;
`else
    assign cancel_v = '0;
`endif

    // A cancel beats a simultaneous arm of the same slot
    assign arm_v  = arm_i & ~cancel_v;
    assign busy_o = (|pend_q) | (|act_q);

    // Expired active slots and earliest deadline (strict < keeps the lowest index on ties)
    always_comb begin
        min_rem = '1;
        expired = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            expired[i] = act_q[i] && (rem_q[i] == '0);
            if (act_q[i] && (rem_q[i] < min_rem)) begin
                min_rem = rem_q[i];
            end
        end
    end

    // FSM state register
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_CFG;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CFG:    if (apb_done) state_d = ST_IDLE;
            ST_IDLE:   if (|pend_q) state_d = ST_MERGE;
            ST_WAIT: begin
                if (hit_q)        state_d = ST_UPDATE;
                else if (|pend_q) state_d = ST_SYNC;
            end
            ST_SYNC:   if (apb_done) state_d = ST_UPDATE;
            ST_UPDATE: state_d = ST_MERGE;
            ST_MERGE:  state_d = ST_FIRE;
            ST_FIRE:   state_d = (|(act_q & ~expired & ~cancel_v)) ? ST_PROG : ST_IDLE;
            ST_PROG:   if (apb_done) state_d = ST_WAIT;
            default:   state_d = ST_CFG;
        endcase
    end

    // FSM outputs: APB request per state and expiry pulses in FIRE
    always_comb begin
        apb_start = 1'b0;
        apb_write = 1'b0;
        apb_addr  = ADDR_TIMER;
        apb_wdata = '0;
        done_o    = '0;
        case (state_q)
            ST_CFG: begin
                apb_start = 1'b1;
                apb_write = 1'b1;
                apb_addr  = ADDR_CTRL;
                apb_wdata = CTRL_WORD;
            end
            ST_SYNC: begin
                apb_start = 1'b1;
            end
            ST_PROG: begin
                apb_start = 1'b1;
                apb_write = 1'b1;
                apb_addr  = ADDR_CMP;
                apb_wdata = min_rem;
            end
            ST_FIRE: done_o = expired & ~cancel_v;
            default: ;
        endcase
    end

    // Scheduler datapath: compare flag, elapsed capture and per-slot bookkeeping
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            pend_q    <= '0;
            act_q     <= '0;
            dly_q     <= '0;
            rem_q     <= '0;
            cmp_q     <= '0;
            elapsed_q <= '0;
            hit_q     <= 1'b0;
        end else begin
            if (irq_cmp_i) hit_q <= 1'b1;
            // A CMP write restarts the timer, so any earlier hit is stale
            if (state_q == ST_PROG && apb_done) begin
                cmp_q <= min_rem;
                hit_q <= 1'b0;
            end
            if (state_q == ST_WAIT && hit_q) elapsed_q <= cmp_q;
            if (state_q == ST_SYNC && apb_done) elapsed_q <= hit_q ? cmp_q : apb_rdata;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (state_q == ST_UPDATE && act_q[i]) begin
                    rem_q[i] <= (rem_q[i] > elapsed_q) ? rem_q[i] - elapsed_q : '0;
                end
                if (state_q == ST_MERGE && pend_q[i]) begin
                    act_q[i]  <= 1'b1;
                    rem_q[i]  <= dly_q[i];
                    pend_q[i] <= 1'b0;
                end
                if (state_q == ST_FIRE && expired[i]) act_q[i] <= 1'b0;
                // An arm in the MERGE cycle overrides the clear and stays pending
                if (arm_v[i]) begin
                    dly_q[i]  <= delay_i[i];
                    pend_q[i] <= 1'b1;
                end
                if (cancel_v[i]) begin
                    pend_q[i] <= 1'b0;
                    act_q[i]  <= 1'b0;
                end
            end
        end
    end

    timer_sched_apb_master #(
        .ADDR_W (APB_ADDR_WIDTH)
    ) u_apb (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .start   (apb_start),
        .write   (apb_write),
        .addr    (apb_addr),
        .wdata   (apb_wdata),
        .done    (apb_done),
        .rdata   (apb_rdata),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PWRITE  (PWRITE),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY)
    );

endmodule

// File: doc/timer_sched.md
# timer_sched

Alarm scheduler that shares one APB timer among `NUM_REQ` requesters.
- Each requester arms a one-shot delay in timer ticks. The block programs the timer's compare register with the earliest pending deadline and waits for the compare interrupt. It then pulses `done_o` for every expired requester and reprograms the next deadline.
- Sits between local requesters and the timer's APB slave port; it is the timer's only APB master.

## Interface
- `NUM_REQ`, 4: requester count (2..8).
- `APB_ADDR_WIDTH`, 12: APB address width.
- `PRESCALE`, 1: timer prescaler field, 1..7. Must be nonzero; the timer does not count with prescaler 0.
- `HCLK` in 1: clock.
- `HRESETn` in 1: asynchronous active-low reset.
- `arm_i` in `NUM_REQ`: one-cycle arm pulse per requester.
- `delay_i` in `NUM_REQ`x32: delay in ticks, sampled with `arm_i`.
- `done_o` out `NUM_REQ`: one-cycle expiry pulse.
- `busy_o` out 1: any slot active or pending.
- `PADDR` out `APB_ADDR_WIDTH`, `PWDATA` out 32, `PWRITE` out 1, `PSEL` out 1, `PENABLE` out 1: APB master request.
- `PRDATA` in 32, `PREADY` in 1, `PSLVERR` in 1: APB master response; `PSLVERR` is ignored.
- `irq_cmp_i` in 1: timer compare interrupt.

## Operation
- Timer map: TIMER at 0x0, CTRL at 0x4, CMP at 0x8. Writing CMP clears TIMER to 0.
- Per slot: `pend_q`, `dly_q` (latched delay), `act_q`, `rem_q` (remaining ticks). Scheduler holds `cmp_q` (last CMP value) and `hit_q` (sticky compare flag).
- `arm_i[i]`, any cycle: sets `dly_q[i] = delay_i[i]` and `pend_q[i] = 1`. Re-arming an active slot restarts it.
- `hit_q`: set on `irq_cmp_i` in any state; cleared by every CMP write.
- FSM states:
  - CFG: APB write CTRL = (`PRESCALE`<<3)|1, then go to IDLE.
  - IDLE: if `pend_q != 0`, go to MERGE.
  - WAIT: if `hit_q`, go to UPDATE with elapsed = `cmp_q`. Else if `pend_q != 0`, go to SYNC.
  - SYNC: APB read TIMER. Elapsed = `hit_q` ? `cmp_q` : `PRDATA`. Go to UPDATE.
  - UPDATE: `rem_q -= elapsed`, saturating at 0, for all active slots. Go to MERGE.
  - MERGE: copy every `pend_q` slot into `act_q`/`rem_q` and clear those `pend_q` bits. An arm pulse in this cycle stays pending. Go to FIRE.
  - FIRE: pulse `done_o` for every active slot with `rem_q == 0` and clear its `act_q`. If any active slot remains, go to PROG; otherwise go to IDLE.
  - PROG: APB write CMP = min(active `rem_q`), lowest index on a tie. Load `cmp_q` and clear `hit_q`. Go to WAIT.
- `delay_i = 0`: fires in FIRE with no timer access.
- `irq_cmp_i` in IDLE, CFG or FIRE with nothing active: only sets `hit_q`. PROG clears it before use.
- Ticks that elapse between the SYNC read and the PROG write are lost. Up to 1 tick of lateness per resync is accepted.

## Timing
- Reset values: `done_o` = 0, `busy_o` = 0, `PSEL`/`PENABLE`/`PWRITE` = 0, `PADDR`/`PWDATA` = 0. All slot registers clear. FSM enters CFG.
- APB transfers: SETUP with `PSEL`=1, `PENABLE`=0 for one cycle. ACCESS with `PENABLE`=1, held until `PREADY`. `PRDATA` is sampled in the ACCESS cycle where `PREADY`=1.
- Arm to MERGE from IDLE: 2 cycles.
- Zero-delay arm: `done_o` 3 cycles after `arm_i`.
- Compare hit to `done_o`: 4 cycles (WAIT→UPDATE→MERGE→FIRE).
- Reset mid-transfer drops `PSEL` immediately and discards all slots.

## Configuration
- `TIMER_SCHED_CANCEL_EN` defined:
  - Adds input `cancel_i` [`NUM_REQ`].
  - Cancel clears `pend_q[i]` and `act_q[i]`; no `done_o` is produced.
  - Cancel beats a simultaneous arm of the same slot.
  - If the cancelled slot was the last active one, a later compare hit leads to FIRE with nothing to pulse, then IDLE.
- `TIMER_SCHED_CANCEL_EN` undefined: no port; slots clear only by expiry.

## Structure
- `timer_sched_pkg`: register offsets, CTRL enable bit and prescaler shift, FSM state enum, `elapsed`/`rem` width constant.
- Sub-module `timer_sched_apb_master`: single-transfer APB engine with `start`/`write`/`addr`/`wdata` in and `done`/`rdata` out. The top level holds the FSM, slot array and min-finder.

## Test plan
- Reset, then hold `PREADY`=1 → first APB write is CTRL = 0x9 (`PRESCALE`=1); `busy_o` = 0.
- Arm slot 0 with delay 0 → `done_o` = 0001 three cycles later; no CMP write.
- Arm slot 1 = 10, slot 2 = 10 in the same cycle → CMP written 10; on `irq_cmp_i`, `done_o` = 0110 in one cycle.
- Arm slot 0 = 100; model TIMER reads 40; then arm slot 3 = 20 → SYNC read, CMP = 20. After that hit, slot 3 fires and CMP = 40.
- Assert `irq_cmp_i` during the SYNC ACCESS phase with `PRDATA` = 0 → elapsed taken as `cmp_q`; expired slots fire.
- `TIMER_SCHED_CANCEL_EN`: arm slot 2 = 50, cancel in the next cycle → no `done_o`; after the compare hit, `busy_o` = 0.
